// File: rtl/ren_wb_cmd_master.sv
// ren_wb_cmd_master: command FIFO feeding single Wishbone classic cycles, with
// bus timeout and a valid/ready response stream. Option: REN_WBM_RDCHK_EN.
module ren_wb_cmd_master #(
    parameter  int ADDR_WIDTH     = 32,
    parameter  int DATA_WIDTH     = 32,
    parameter  int FIFO_DEPTH     = 4,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int SEL_WIDTH      = DATA_WIDTH / 8,
    localparam int LVL_WIDTH      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
`ifdef REN_WBM_RDCHK_EN
    input  logic [DATA_WIDTH-1:0] cmd_exp_i,
    output logic                  rsp_mismatch_o,
`endif
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_we_o,
    output logic [ADDR_WIDTH-1:0] rsp_adr_o,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [SEL_WIDTH-1:0]  wbm_sel_o,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [DATA_WIDTH-1:0] wbm_dat_o,
    input  logic                  wbm_ack_i,
    input  logic [DATA_WIDTH-1:0] wbm_dat_i,
    output logic                  busy_o,
    output logic [LVL_WIDTH-1:0]  fifo_level_o
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int TMO_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_WIDTH-1:0] TMO_LAST =
        TMO_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

`ifdef REN_WBM_RDCHK_EN
    localparam int XW = DATA_WIDTH;
`else
    localparam int XW = 0;
`endif
    localparam int DAT_LSB = XW;
    localparam int ADR_LSB = DAT_LSB + DATA_WIDTH;
    localparam int SEL_LSB = ADR_LSB + ADDR_WIDTH;
    localparam int WE_BIT  = SEL_LSB + SEL_WIDTH;
    localparam int EW      = WE_BIT + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RSP
    } state_e;

    state_e                state_q, state_d;

    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [EW-1:0]         mem_d [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_WIDTH-1:0]  level_q, level_d;

    logic [TMO_WIDTH-1:0]  tmo_q, tmo_d;

    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;

    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_we_q, rsp_we_d;
    logic [ADDR_WIDTH-1:0] rsp_adr_q, rsp_adr_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic                  rsp_err_q, rsp_err_d;

`ifdef REN_WBM_RDCHK_EN
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic                  mism_q, mism_d;
    logic [DATA_WIDTH-1:0] rd_mask;
`endif

    logic [EW-1:0]         push_ent;
    logic [EW-1:0]         head;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

`ifdef REN_WBM_RDCHK_EN
    assign push_ent = {cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i, cmd_exp_i};
`else
    assign push_ent = {cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i};
`endif

    assign head  = mem_q[rd_ptr_q];
    assign full  = (level_q == LVL_WIDTH'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign push  = cmd_valid_i & ~full;

`ifdef REN_WBM_RDCHK_EN
    always_comb begin
        rd_mask = '0;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            rd_mask[i*8 +: 8] = {8{sel_q[i]}};
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        tmo_d       = tmo_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_adr_d   = rsp_adr_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
`ifdef REN_WBM_RDCHK_EN
        exp_d       = exp_q;
        mism_d      = mism_q;
`endif
        pop         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                we_d  = 1'b0;
                sel_d = '0;
                adr_d = '0;
                dat_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    cyc_d   = 1'b1;
                    tmo_d   = '0;
                    we_d    = head[WE_BIT];
                    sel_d   = head[SEL_LSB +: SEL_WIDTH];
                    adr_d   = head[ADR_LSB +: ADDR_WIDTH];
                    dat_d   = head[DAT_LSB +: DATA_WIDTH];
`ifdef REN_WBM_RDCHK_EN
                    exp_d   = head[DATA_WIDTH-1:0];
`endif
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // An ack on the last allowed cycle takes priority over timeout.
                if (wbm_ack_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = we_q;
                    rsp_adr_d   = adr_q;
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
`ifdef REN_WBM_RDCHK_EN
                    mism_d      = ~we_q & (|((wbm_dat_i ^ exp_q) & rd_mask));
`endif
                end else if (TMO_EN && tmo_q == TMO_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = we_q;
                    rsp_adr_d   = adr_q;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
`ifdef REN_WBM_RDCHK_EN
                    mism_d      = 1'b0;
`endif
                end else if (TMO_EN) begin
                    tmo_d = tmo_q + TMO_WIDTH'(1);
                end
                if (rsp_valid_d) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    adr_d   = '0;
                    dat_d   = '0;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rsp_we_d    = 1'b0;
                    rsp_adr_d   = '0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b0;
`ifdef REN_WBM_RDCHK_EN
                    mism_d      = 1'b0;
`endif
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = push_ent;
            wr_ptr_d        = wr_ptr_q + PTR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
        level_d = level_q + LVL_WIDTH'(push) - LVL_WIDTH'(pop);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= S_IDLE;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            tmo_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_adr_q   <= '0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
`ifdef REN_WBM_RDCHK_EN
            exp_q       <= '0;
            mism_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            tmo_q       <= tmo_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_adr_q   <= rsp_adr_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
`ifdef REN_WBM_RDCHK_EN
            exp_q       <= exp_d;
            mism_q      <= mism_d;
`endif
        end
    end

    // Ready is held low while reset is asserted.
    assign cmd_ready_o  = wb_rst_ni & ~full;
    assign busy_o       = (state_q != S_IDLE) | ~empty;
    assign fifo_level_o = level_q;

    assign wbm_cyc_o    = cyc_q;
    assign wbm_stb_o    = cyc_q;
    assign wbm_we_o     = we_q;
    assign wbm_sel_o    = sel_q;
    assign wbm_adr_o    = adr_q;
    assign wbm_dat_o    = dat_q;

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_we_o     = rsp_we_q;
    assign rsp_adr_o    = rsp_adr_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_err_o    = rsp_err_q;
`ifdef REN_WBM_RDCHK_EN
    assign rsp_mismatch_o = mism_q;
`endif

endmodule

// File: tb/tb_ren_wb_cmd_master.sv
// tb_ren_wb_cmd_master: transaction-level model of the command master,
// directed scenarios then randomized traffic with a noisy Wishbone slave.
module tb_ren_wb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int D  = 4;
    localparam int T  = 16;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [SW-1:0] cmd_sel;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic          rsp_valid, rsp_ready, rsp_we, rsp_err;
    logic [AW-1:0] rsp_adr;
    logic [DW-1:0] rsp_dat;
    logic          cyc, stb, wwe, ack;
    logic [SW-1:0] wsel;
    logic [AW-1:0] wadr;
    logic [DW-1:0] wdat, rdat_i;
    logic          busy;
    logic [LW-1:0] level;
`ifdef REN_WBM_RDCHK_EN
    logic [DW-1:0] cmd_exp;
    logic          rsp_mism;
`endif

    always #5 clk = ~clk;

    ren_wb_cmd_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .FIFO_DEPTH(D), .TIMEOUT_CYCLES(T)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_we_i(cmd_we), .cmd_sel_i(cmd_sel),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
`ifdef REN_WBM_RDCHK_EN
        .cmd_exp_i(cmd_exp), .rsp_mismatch_o(rsp_mism),
`endif
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_we_o(rsp_we), .rsp_adr_o(rsp_adr),
        .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(wwe),
        .wbm_sel_o(wsel), .wbm_adr_o(wadr), .wbm_dat_o(wdat),
        .wbm_ack_i(ack), .wbm_dat_i(rdat_i),
        .busy_o(busy), .fifo_level_o(level)
    );

    typedef struct {
        logic          we;
        logic [SW-1:0] sel;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [DW-1:0] exp;
    } cmd_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic          err;
        logic          mism;
    } rsp_t;

    cmd_t        src[$];
    cmd_t        mq[$];
    int          waits[$];
    logic [31:0] rdq[$];

    bit   m_fly, m_bus;
    int   m_cnt, m_wait;
    cmd_t m_cur;
    rsp_t m_rsp;

    int vprob = 100;
    int rdy_mode = 0;
    bit noise = 0;
    bit rand_wait = 0;

    int checks = 0;
    int failures = 0;
    int dut_acc = 0;
    bit dut_take = 0;
    int stb_run = 0;
    int stb_len = 0;
    logic          bus_we_seen = 1'b0;
    logic [AW-1:0] bus_adr_seen = '0;

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [DW-1:0] mask_of(logic [SW-1:0] s);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < SW; i++) if (s[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.we  = 1'($urandom_range(0, 1));
        c.sel = SW'($urandom);
        c.adr = $urandom;
        c.dat = $urandom;
        c.exp = $urandom;
        return c;
    endfunction

    function automatic cmd_t mk(logic we, logic [SW-1:0] s, logic [AW-1:0] a,
                                logic [DW-1:0] d, logic [DW-1:0] x);
        cmd_t c;
        c.we = we; c.sel = s; c.adr = a; c.dat = d; c.exp = x;
        return c;
    endfunction

    // Outcome of one rising edge, from the queued-command rules.
    task automatic model_edge();
        bit   take;
        cmd_t c;
        take = cmd_valid && (mq.size() < D);
        if (take) c = src[0];
        if (!m_fly) begin
            if (mq.size() > 0) begin
                m_cur = mq.pop_front();
                m_fly = 1; m_bus = 1; m_cnt = 0;
                if (waits.size() > 0) m_wait = waits.pop_front();
                else if (rand_wait)
                    m_wait = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 3);
                else m_wait = 0;
            end
        end else if (m_bus) begin
            if (ack) begin
                m_rsp.we   = m_cur.we;
                m_rsp.adr  = m_cur.adr;
                m_rsp.dat  = m_cur.we ? '0 : rdat_i;
                m_rsp.err  = 1'b0;
                m_rsp.mism = !m_cur.we &&
                    (((rdat_i ^ m_cur.exp) & mask_of(m_cur.sel)) != '0);
                m_bus = 0;
            end else if (m_cnt == T - 1) begin
                m_rsp.we   = m_cur.we;
                m_rsp.adr  = m_cur.adr;
                m_rsp.dat  = '0;
                m_rsp.err  = 1'b1;
                m_rsp.mism = 1'b0;
                m_bus = 0;
            end else begin
                m_cnt++;
            end
        end else if (rsp_ready) begin
            m_fly = 0;
        end
        if (take) begin
            mq.push_back(c);
            void'(src.pop_front());
        end
        if (dut_take) dut_acc++;
    endtask

    task automatic compare();
        chk("cmd_ready", 64'(cmd_ready), 64'(mq.size() < D));
        chk("fifo_level", 64'(level), 64'(mq.size()));
        chk("busy", 64'(busy), 64'(m_fly || mq.size() > 0));
        chk("cyc", 64'(cyc), 64'(m_bus));
        chk("stb", 64'(stb), 64'(m_bus));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_fly && !m_bus));
        if (m_bus) begin
            chk("wbm_we", 64'(wwe), 64'(m_cur.we));
            chk("wbm_sel", 64'(wsel), 64'(m_cur.sel));
            chk("wbm_adr", 64'(wadr), 64'(m_cur.adr));
            chk("wbm_dat", 64'(wdat), 64'(m_cur.dat));
        end else if (!m_fly) begin
            chk("idle_we", 64'(wwe), 64'(0));
            chk("idle_sel", 64'(wsel), 64'(0));
            chk("idle_adr", 64'(wadr), 64'(0));
            chk("idle_dat", 64'(wdat), 64'(0));
        end
        if (m_fly && !m_bus) begin
            chk("rsp_we", 64'(rsp_we), 64'(m_rsp.we));
            chk("rsp_adr", 64'(rsp_adr), 64'(m_rsp.adr));
            chk("rsp_dat", 64'(rsp_dat), 64'(m_rsp.dat));
            chk("rsp_err", 64'(rsp_err), 64'(m_rsp.err));
`ifdef REN_WBM_RDCHK_EN
            chk("rsp_mism", 64'(rsp_mism), 64'(m_rsp.mism));
`endif
        end
        if (stb) begin
            stb_run++;
            bus_we_seen  = wwe;
            bus_adr_seen = wadr;
        end else if (stb_run > 0) begin
            stb_len = stb_run;
            stb_run = 0;
        end
    endtask

    task automatic set_rdy(int m);
        rdy_mode  = m;
        rsp_ready = (m == 1) ? 1'b1 :
                    (m == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic drive();
        cmd_t c;
        if (src.size() > 0 && $urandom_range(0, 99) < vprob) begin
            c = src[0];
            cmd_valid = 1'b1;
        end else begin
            c = rand_cmd();
            cmd_valid = 1'b0;
        end
        cmd_we  = c.we;
        cmd_sel = c.sel;
        cmd_adr = c.adr;
        cmd_dat = c.dat;
`ifdef REN_WBM_RDCHK_EN
        cmd_exp = c.exp;
`endif
        if (m_bus && m_cnt == m_wait) begin
            ack    = 1'b1;
            rdat_i = (rdq.size() > 0) ? rdq.pop_front() : $urandom;
        end else begin
            ack    = noise && !m_bus && ($urandom_range(0, 3) == 0);
            rdat_i = $urandom;
        end
        set_rdy(rdy_mode);
        dut_take = cmd_valid && cmd_ready;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
        drive();
    endtask

    task automatic wait_rsp(string n, int maxc);
        int i;
        i = 0;
        while (!rsp_valid && i < maxc) begin
            step();
            i++;
        end
        chk({n, "_rsp_seen"}, 64'(rsp_valid), 64'(1));
    endtask

    task automatic model_clear();
        src.delete(); mq.delete(); waits.delete(); rdq.delete();
        m_fly = 0; m_bus = 0; m_cnt = 0;
        cmd_valid = 1'b0; ack = 1'b0; dut_take = 0;
    endtask

    initial begin
        cmd_valid = 0; cmd_we = 0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
        ack = 0; rdat_i = '0; rsp_ready = 0;
`ifdef REN_WBM_RDCHK_EN
        cmd_exp = '0;
`endif
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_cyc", 64'(cyc), 64'(0));
        chk("rst_ready", 64'(cmd_ready), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 64'(cmd_ready), 64'(1));
        compare();
        drive();

        // Write with two wait states.
        set_rdy(0);
        src.push_back(mk(1, 4'hF, 32'h100, 32'h0002_0100, 32'h0));
        waits.push_back(2);
        wait_rsp("t1", 20);
        chk("t1_stb_len", 64'(stb_len), 64'(3));
        chk("t1_bus_we", 64'(bus_we_seen), 64'(1));
        chk("t1_bus_adr", 64'(bus_adr_seen), 64'h100);
        chk("t1_rsp_we", 64'(rsp_we), 64'(1));
        chk("t1_rsp_dat", 64'(rsp_dat), 64'(0));
        chk("t1_rsp_err", 64'(rsp_err), 64'(0));
        set_rdy(1);
        step();

        // Read; response held until consumed.
        set_rdy(0);
        src.push_back(mk(0, 4'hF, 32'h300, 32'h0, 32'h0));
        waits.push_back(1);
        rdq.push_back(32'hDEAD_BEEF);
        wait_rsp("t2", 20);
        repeat (4) step();
        chk("t2_hold", 64'(rsp_valid), 64'(1));
        chk("t2_dat", 64'(rsp_dat), 64'hDEAD_BEEF);
        chk("t2_adr", 64'(rsp_adr), 64'h300);
        set_rdy(1);
        step();
        chk("t2_release", 64'(rsp_valid), 64'(0));

        // Back-pressure: six writes, responses stalled.
        set_rdy(0);
        dut_acc = 0;
        for (int i = 0; i < 6; i++) begin
            src.push_back(mk(1, 4'hF, 32'h1000 + 32'(i * 4), 32'(i), 32'h0));
            waits.push_back(0);
        end
        repeat (12) step();
        chk("t3_acc5", 64'(dut_acc), 64'(5));
        chk("t3_level", 64'(level), 64'(4));
        chk("t3_ready", 64'(cmd_ready), 64'(0));
        set_rdy(1);
        step();
        set_rdy(0);
        repeat (6) step();
        chk("t3_acc6", 64'(dut_acc), 64'(6));
        chk("t3_level2", 64'(level), 64'(4));
        set_rdy(1);
        repeat (30) step();
        chk("t3_drained", 64'(busy), 64'(0));

        // Timeout, then a normal read.
        set_rdy(0);
        src.push_back(mk(1, 4'h3, 32'h500, 32'h55, 32'h0));
        waits.push_back(99);
        src.push_back(mk(0, 4'hF, 32'h504, 32'h0, 32'h0));
        waits.push_back(1);
        rdq.push_back(32'hCAFE_F00D);
        wait_rsp("t4a", 40);
        chk("t4_stb_len", 64'(stb_len), 64'(16));
        chk("t4_err", 64'(rsp_err), 64'(1));
        chk("t4_dat", 64'(rsp_dat), 64'(0));
        set_rdy(1);
        step();
        set_rdy(0);
        wait_rsp("t4b", 20);
        chk("t4b_err", 64'(rsp_err), 64'(0));
        chk("t4b_dat", 64'(rsp_dat), 64'hCAFE_F00D);
        chk("t4b_adr", 64'(rsp_adr), 64'h504);
        set_rdy(1);
        step();

`ifdef REN_WBM_RDCHK_EN
        set_rdy(0);
        src.push_back(mk(0, 4'b0011, 32'h600, 32'h0, 32'h1234_5678));
        src.push_back(mk(0, 4'b0011, 32'h604, 32'h0, 32'h1234_5678));
        waits.push_back(0); waits.push_back(0);
        rdq.push_back(32'hFFFF_5678); rdq.push_back(32'h1234_5679);
        wait_rsp("t6a", 20);
        chk("t6_match", 64'(rsp_mism), 64'(0));
        set_rdy(1);
        step();
        set_rdy(0);
        wait_rsp("t6b", 20);
        chk("t6_mismatch", 64'(rsp_mism), 64'(1));
        set_rdy(1);
        step();
`endif

        // Asynchronous reset in the middle of a bus cycle.
        set_rdy(0);
        for (int i = 0; i < 4; i++) begin
            src.push_back(mk(1, 4'hF, 32'h700 + 32'(i), 32'h0, 32'h0));
            waits.push_back(99);
        end
        repeat (6) step();
        chk("t5_pre_cyc", 64'(cyc), 64'(1));
        chk("t5_pre_level", 64'(level), 64'(3));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_cyc", 64'(cyc), 64'(0));
        chk("t5_stb", 64'(stb), 64'(0));
        chk("t5_level", 64'(level), 64'(0));
        chk("t5_rsp", 64'(rsp_valid), 64'(0));
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare();
        drive();
        set_rdy(1);
        repeat (10) step();
        chk("t5_no_rsp", 64'(rsp_valid), 64'(0));

        // Randomized traffic with spurious acks outside bus cycles.
        rand_wait = 1;
        noise = 1;
        vprob = 60;
        set_rdy(2);
        for (int n = 0; n < 2000; n++) begin
            if (src.size() < 4) src.push_back(rand_cmd());
            step();
        end
        src.delete();
        set_rdy(1);
        repeat (300) step();
        chk("rand_drained", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
